max7219_emul: RTL and testbench

- Bench-side receiver model for the DUT's MAX7219 serial display interface (o_max7219_clk / o_max7219_load / o_max7219_data). It sits directly downstream of the DUT.
- Oversamples the three lines on the bench clock, deserialises 16-bit frames and commits them on the LOAD rising edge.
- Decodes each committed frame into a MAX7219-compatible register file.
- Exposes the last frame, a frame-valid pulse for wait_event, and a register readback port plus error flags for check_level.

---
 rtl/max7219_emul_pkg.sv | 46 ++++
 rtl/max7219_emul_sync_edge.sv | 28 ++
 rtl/max7219_emul.sv | 127 ++++++++++++
 tb/tb_max7219_emul.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/max7219_emul_pkg.sv
// Shared constants, state type and register-mask helper for the MAX7219 receiver model.
package max7219_emul_pkg;

    localparam int unsigned C_FRAME_WIDTH = 16;

    localparam logic [3:0] C_ADDR_NOOP       = 4'h0;
    localparam logic [3:0] C_ADDR_DIGIT0     = 4'h1;
    localparam logic [3:0] C_ADDR_DIGIT1     = 4'h2;
    localparam logic [3:0] C_ADDR_DIGIT2     = 4'h3;
    localparam logic [3:0] C_ADDR_DIGIT3     = 4'h4;
    localparam logic [3:0] C_ADDR_DIGIT4     = 4'h5;
    localparam logic [3:0] C_ADDR_DIGIT5     = 4'h6;
    localparam logic [3:0] C_ADDR_DIGIT6     = 4'h7;
    localparam logic [3:0] C_ADDR_DIGIT7     = 4'h8;
    localparam logic [3:0] C_ADDR_DECODE     = 4'h9;
    localparam logic [3:0] C_ADDR_INTENSITY  = 4'hA;
    localparam logic [3:0] C_ADDR_SCAN_LIMIT = 4'hB;
    localparam logic [3:0] C_ADDR_SHUTDOWN   = 4'hC;
    localparam logic [3:0] C_ADDR_TEST       = 4'hF;

    localparam logic [7:0] C_RST_REG      = 8'h00;
    localparam logic [7:0] C_RST_SHUTDOWN = 8'h00;

    typedef enum logic {
        IDLE,
        COMMIT
    } t_max7219_state;

    // Writable bits per address; unmapped addresses get an all-zero mask so they always read 0.
    function automatic logic [7:0] f_reg_mask(input logic [3:0] addr);
        logic [7:0] mask;
        mask = '0;
        case (addr)
            C_ADDR_DIGIT0, C_ADDR_DIGIT1, C_ADDR_DIGIT2, C_ADDR_DIGIT3,
            C_ADDR_DIGIT4, C_ADDR_DIGIT5, C_ADDR_DIGIT6, C_ADDR_DIGIT7,
            C_ADDR_DECODE:     mask = 8'hFF;
            C_ADDR_INTENSITY:  mask = 8'h0F;
            C_ADDR_SCAN_LIMIT: mask = 8'h07;
            C_ADDR_SHUTDOWN:   mask = 8'h01;
            C_ADDR_TEST:       mask = 8'h01;
            default:           mask = '0;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/max7219_emul_sync_edge.sv
// Multi-flop synchroniser for one asynchronous line, with a history flop for rising-edge detection.
module max7219_sync_edge #(
    parameter int unsigned G_SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic level_o,
    output logic rise_o
);

    logic [G_SYNC_STAGES-1:0] sync_q;
    logic                     hist_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[G_SYNC_STAGES-2:0], async_i};
            hist_q <= sync_q[G_SYNC_STAGES-1];
        end
    end

    assign level_o = sync_q[G_SYNC_STAGES-1];
    assign rise_o  = sync_q[G_SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/max7219_emul.sv
// MAX7219 receiver model: oversamples the serial lines, commits 16-bit frames on LOAD rise, decodes a register file.
module max7219_emul
    import max7219_emul_pkg::*;
#(
    parameter int unsigned G_SYNC_STAGES = 2,
    parameter int unsigned G_CNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_max_clk,
    input  logic                   i_max_load,
    input  logic                   i_max_din,
    input  logic [3:0]             i_reg_addr,
    output logic [7:0]             o_reg_rdata,
    output logic [15:0]            o_frame,
    output logic                   o_frame_val,
    output logic                   o_frame_err,
    input  logic                   i_clr_err,
    output logic                   o_err_sticky,
    output logic [G_CNT_WIDTH-1:0] o_frame_cnt,
    output logic                   o_shutdown_n
);

    logic clk_rise, load_rise, din_lvl;
    logic clk_lvl_unused, load_lvl_unused;

    max7219_sync_edge #(.G_SYNC_STAGES(G_SYNC_STAGES)) u_sync_clk (
        .clk(clk), .rst_n(rst_n), .async_i(i_max_clk), .level_o(clk_lvl_unused), .rise_o(clk_rise)
    );
    max7219_sync_edge #(.G_SYNC_STAGES(G_SYNC_STAGES)) u_sync_load (
        .clk(clk), .rst_n(rst_n), .async_i(i_max_load), .level_o(load_lvl_unused), .rise_o(load_rise)
    );
    max7219_sync_edge #(.G_SYNC_STAGES(G_SYNC_STAGES)) u_sync_din (
        .clk(clk), .rst_n(rst_n), .async_i(i_max_din), .level_o(din_lvl), .rise_o()
    );

    t_max7219_state             state_q, state_d;
    logic [C_FRAME_WIDTH-1:0]   shift_q, shift_d, frame_q, frame_d;
    logic [5:0]                 cnt_q, cnt_d;
    logic                       val_q, val_d, err_q, err_d, sticky_q, sticky_d;
    logic [G_CNT_WIDTH-1:0]     fcnt_q, fcnt_d;
    logic [7:0]                 regs_q [16];
    logic [7:0]                 rdata_q;
    logic                       wr_en;
    logic [3:0]                 wr_addr;
    logic [7:0]                 wr_data;

    // The shift is resolved before the commit test so a clk/load rise in the same cycle includes that bit.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        frame_d = frame_q;
        fcnt_d  = fcnt_q;
        val_d   = 1'b0;
        err_d   = 1'b0;
        wr_en   = 1'b0;
        if (clk_rise) begin
            shift_d = {shift_q[C_FRAME_WIDTH-2:0], din_lvl};
            if (cnt_q != 6'h3F) cnt_d = cnt_q + 6'd1;
        end
        wr_addr = shift_d[11:8];
        wr_data = shift_d[7:0];
        case (state_q)
            IDLE: begin
                if (load_rise) begin
                    state_d = COMMIT;
                    if (cnt_d != 6'd0) begin
                        err_d = (cnt_d != 6'd16);
                        if (cnt_d >= 6'd16) begin
                            frame_d = shift_d;
                            val_d   = 1'b1;
                            wr_en   = 1'b1;
                            fcnt_d  = fcnt_q + G_CNT_WIDTH'(1);
                        end
                    end
                    cnt_d = '0;
                end
            end
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        sticky_d = err_d | (sticky_q & ~i_clr_err);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            cnt_q    <= '0;
            frame_q  <= '0;
            fcnt_q   <= '0;
            val_q    <= 1'b0;
            err_q    <= 1'b0;
            sticky_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            cnt_q    <= cnt_d;
            frame_q  <= frame_d;
            fcnt_q   <= fcnt_d;
            val_q    <= val_d;
            err_q    <= err_d;
            sticky_q <= sticky_d;
            rdata_q  <= regs_q[i_reg_addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 16; i++) regs_q[i] <= C_RST_REG;
            regs_q[C_ADDR_SHUTDOWN] <= C_RST_SHUTDOWN;
        end else if (wr_en) begin
            regs_q[wr_addr] <= wr_data & f_reg_mask(wr_addr);
        end
    end

    assign o_reg_rdata  = rdata_q;
    assign o_frame      = frame_q;
    assign o_frame_val  = val_q;
    assign o_frame_err  = err_q;
    assign o_err_sticky = sticky_q;
    assign o_frame_cnt  = fcnt_q;
    assign o_shutdown_n = regs_q[C_ADDR_SHUTDOWN][0];

endmodule

// File: tb/tb_max7219_emul.sv
// Self-checking bench for max7219_emul: scoreboarded frame pulses plus table-driven register readback.
module tb_max7219_emul;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mclk = 1'b0, load = 1'b0, din = 1'b0;
    logic [3:0]  addr = '0;
    logic        clr = 1'b0;
    logic [7:0]  rdata;
    logic [15:0] frame;
    logic        fval, ferr, sticky, shdn_n;
    logic [15:0] fcnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        val;
        logic        err;
        logic [15:0] frame;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        logic [3:0] addr;
        logic [7:0] exp;
    } rb_t;
    rb_t rb_tab[16];

    always #5 clk = ~clk;

    max7219_emul #(.G_SYNC_STAGES(2), .G_CNT_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_max_clk(mclk), .i_max_load(load), .i_max_din(din),
        .i_reg_addr(addr), .o_reg_rdata(rdata),
        .o_frame(frame), .o_frame_val(fval), .o_frame_err(ferr),
        .i_clr_err(clr), .o_err_sticky(sticky),
        .o_frame_cnt(fcnt), .o_shutdown_n(shdn_n)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every val/err pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && (fval || ferr)) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: got val=%0b err=%0b frame=%h expected no pulse", fval, ferr, frame);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if (fval !== e.val || ferr !== e.err || frame !== e.frame) begin
                    errors++;
                    $display("FAIL frame_pulse: got val=%0b err=%0b frame=%h expected val=%0b err=%0b frame=%h",
                             fval, ferr, frame, e.val, e.err, e.frame);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic shift_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            din = v[i];
            tick(2);
            mclk = 1'b1;
            tick(2);
            mclk = 1'b0;
        end
    endtask

    task automatic pulse_load();
        load = 1'b1;
        tick(4);
        load = 1'b0;
        tick(4);
    endtask

    task automatic send(input logic [31:0] v, input int n, input logic ev, input logic ee, input logic [15:0] ef);
        exp_t e;
        e.val = ev; e.err = ee; e.frame = ef;
        sb_q.push_back(e);
        shift_bits(v, n);
        pulse_load();
    endtask

    task automatic readback(input string name, input logic [3:0] a, input logic [7:0] exp);
        addr = a;
        tick(2);
        chk(name, {24'h0, rdata}, {24'h0, exp});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int lat;
        exp_t e;

        // Reset state
        tick(10);
        chk("rst_frame", {16'h0, frame}, 32'h0);
        chk("rst_val_err", {30'h0, fval, ferr}, 32'h0);
        chk("rst_sticky", {31'h0, sticky}, 32'h0);
        chk("rst_cnt", {16'h0, fcnt}, 32'h0);
        chk("rst_shutdown_n", {31'h0, shdn_n}, 32'h0);
        addr = 4'hC;
        tick(2);
        chk("rst_rdata_c", {24'h0, rdata}, 32'h0);
        rst_n = 1'b1;
        tick(4);
        readback("rst_rb_c", 4'hC, 8'h00);

        // Single frame
        send(32'h0C01, 16, 1'b1, 1'b0, 16'h0C01);
        chk("single_shutdown_n", {31'h0, shdn_n}, 32'h1);
        chk("single_cnt", {16'h0, fcnt}, 32'h1);
        chk("single_sticky", {31'h0, sticky}, 32'h0);
        readback("single_rb_c", 4'hC, 8'h01);

        // Digit sweep and masked registers
        for (int d = 1; d <= 8; d++)
            send(d * 256 + d * 17, 16, 1'b1, 1'b0, 16'(d * 256 + d * 17));
        chk("sweep_cnt", {16'h0, fcnt}, 32'd9);
        send(32'h09AB, 16, 1'b1, 1'b0, 16'h09AB);
        send(32'h0AFF, 16, 1'b1, 1'b0, 16'h0AFF);
        send(32'h0BFF, 16, 1'b1, 1'b0, 16'h0BFF);
        send(32'h0D55, 16, 1'b1, 1'b0, 16'h0D55);
        send(32'h0E66, 16, 1'b1, 1'b0, 16'h0E66);
        send(32'h0055, 16, 1'b1, 1'b0, 16'h0055);
        send(32'hFF03, 16, 1'b1, 1'b0, 16'hFF03);
        chk("regs_cnt", {16'h0, fcnt}, 32'd16);

        rb_tab[0]  = '{4'h0, 8'h00};
        for (int d = 1; d <= 8; d++) rb_tab[d] = '{4'(d), 8'(d * 17)};
        rb_tab[9]  = '{4'h9, 8'hAB};
        rb_tab[10] = '{4'hA, 8'h0F};
        rb_tab[11] = '{4'hB, 8'h07};
        rb_tab[12] = '{4'hC, 8'h01};
        rb_tab[13] = '{4'hD, 8'h00};
        rb_tab[14] = '{4'hE, 8'h00};
        rb_tab[15] = '{4'hF, 8'h01};
        for (int i = 0; i < 16; i++)
            readback($sformatf("rb_tab_%0h", rb_tab[i].addr), rb_tab[i].addr, rb_tab[i].exp);

        // Short frame: error only
        send(32'hA5F, 12, 1'b0, 1'b1, 16'hFF03);
        chk("short_frame_kept", {16'h0, frame}, 32'hFF03);
        chk("short_cnt", {16'h0, fcnt}, 32'd16);
        chk("short_sticky", {31'h0, sticky}, 32'h1);
        readback("short_rb_8", 4'h8, 8'h88);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        tick(1);
        chk("clr_sticky", {31'h0, sticky}, 32'h0);

        // Long frame: last 16 bits commit plus error
        send(32'hF0A07, 20, 1'b1, 1'b1, 16'h0A07);
        chk("long_cnt", {16'h0, fcnt}, 32'd17);
        chk("long_sticky", {31'h0, sticky}, 32'h1);
        readback("long_rb_a", 4'hA, 8'h07);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;

        // Latency from LOAD pin rise to o_frame_val
        e.val = 1'b1; e.err = 1'b0; e.frame = 16'h0F00;
        sb_q.push_back(e);
        shift_bits(32'h0F00, 16);
        tick(2);
        load = 1'b1;
        lat = 0;
        for (int c = 1; c <= 8; c++) begin
            tick(1);
            if (fval) begin
                lat = c;
                break;
            end
        end
        chk("latency", lat, 32'd3);
        load = 1'b0;
        tick(4);
        readback("lat_rb_f", 4'hF, 8'h00);

        // Last clock rise and LOAD rise in the same sample cycle
        e.frame = 16'h0A03;
        sb_q.push_back(e);
        shift_bits(32'h0A03 >> 1, 15);
        din = 1'b1;
        tick(2);
        mclk = 1'b1;
        load = 1'b1;
        tick(2);
        mclk = 1'b0;
        tick(2);
        load = 1'b0;
        tick(4);
        readback("simul_rb_a", 4'hA, 8'h03);

        // Spurious LOAD, then bits shifted while LOAD stays high
        load = 1'b1;
        tick(4);
        e.frame = 16'h0B03;
        sb_q.push_back(e);
        shift_bits(32'h0B03, 16);
        load = 1'b0;
        tick(2);
        pulse_load();
        readback("loadhigh_rb_b", 4'hB, 8'h03);
        chk("pre_reset_cnt", {16'h0, fcnt}, 32'd20);

        // Reset mid-frame
        shift_bits(32'h0B, 8);
        rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(2);
        chk("midrst_cnt", {16'h0, fcnt}, 32'h0);
        chk("midrst_frame", {16'h0, frame}, 32'h0);
        chk("midrst_shutdown_n", {31'h0, shdn_n}, 32'h0);
        send(32'h0B05, 16, 1'b1, 1'b0, 16'h0B05);
        readback("midrst_rb_b", 4'hB, 8'h05);
        chk("midrst_cnt_after", {16'h0, fcnt}, 32'h1);

        tick(10);
        chk("sb_drained", sb_q.size(), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
